// File: rtl/video_pkg.sv
// Shared constants and scan state encoding for the video scan-out path.
package video_pkg;
  localparam int DEF_VBASE = 128;
  localparam int DEF_VSIZE = 80;
  localparam int DEF_COLS  = 10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, SEND} scan_state_t;
endpackage

// File: rtl/video_window_snoop.sv
// Watches CPU stores and keeps a dirty flag for the video window.
module video_window_snoop
  import video_pkg::*;
#(
  parameter int VBASE = DEF_VBASE,
  parameter int VSIZE = DEF_VSIZE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_we,
  input  logic [7:0] cpu_mar,
  input  logic       clr,
  output logic       dirty
);
  localparam logic [7:0] LO = 8'(VBASE);
  localparam logic [7:0] HI = 8'(VBASE + VSIZE - 1);

  logic hit;
  assign hit = cpu_we && (cpu_mar >= LO) && (cpu_mar <= HI);

  // Dirty comes out of reset set so the panel gets an initial paint; a store
  // landing on the same edge as a clear wins, guaranteeing a follow-up frame.
  always_ff @(posedge clock or negedge reset)
    if (!reset)   dirty <= 1'b1;
    else if (hit) dirty <= 1'b1;
    else if (clr) dirty <= 1'b0;
endmodule

// File: rtl/video_scanout.sv
// Reads the video window through RAM port B and streams it to the panel
// driver with sof/eol/eof tagging over a valid/ready handshake.
module video_scanout
  import video_pkg::*;
#(
  parameter int VBASE      = DEF_VBASE,
  parameter int VSIZE      = DEF_VSIZE,
  parameter int COLS       = DEF_COLS,
  parameter int CONTINUOUS = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_we,
  input  logic [7:0] cpu_mar,
  output logic [7:0] vrd_addr,
  input  logic [7:0] vrd_data,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_sof,
  output logic       pix_eol,
  output logic       pix_eof,
  output logic       busy,
  output logic [7:0] frame_cnt
);
  localparam logic [7:0] BASE8    = 8'(VBASE);
  localparam logic [7:0] LAST_IDX = 8'(VSIZE - 1);
  localparam logic [7:0] LAST_COL = 8'(COLS - 1);

  scan_state_t state;
  logic [7:0]  idx;
  logic [7:0]  col;
  logic        dirty;
  logic        go;
  logic        clr;

  assign go       = dirty || (CONTINUOUS != 0);
  assign clr      = (state == IDLE) && go;
  assign vrd_addr = BASE8 + idx;
  assign busy     = (state != IDLE);

  video_window_snoop #(.VBASE(VBASE), .VSIZE(VSIZE)) u_snoop (
    .clock   (clock),
    .reset   (reset),
    .cpu_we  (cpu_we),
    .cpu_mar (cpu_mar),
    .clr     (clr),
    .dirty   (dirty)
  );

  // Scan FSM: one byte per ADDR -> DATA -> SEND pass; outputs are registered
  // and held unchanged while the driver back-pressures in SEND.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      col       <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state <= ADDR;
          idx   <= '0;
          col   <= '0;
        end
        ADDR: state <= DATA;
        DATA: begin
          pix_data  <= vrd_data;
          pix_valid <= 1'b1;
          pix_sof   <= (idx == '0);
          pix_eol   <= (col == LAST_COL);
          pix_eof   <= (idx == LAST_IDX);
          state     <= SEND;
        end
        SEND: if (pix_ready) begin
          pix_valid <= 1'b0;
          if (idx == LAST_IDX) begin
            frame_cnt <= frame_cnt + 8'd1;
            state     <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            col   <= (col == LAST_COL) ? 8'd0 : col + 8'd1;
            state <= ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_video_scanout.sv
// Directed bench for video_scanout: RAM model on port B, transfer monitor,
// one task per scenario.
module tb_video_scanout;
  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_we;
  logic [7:0] cpu_mar;
  logic [7:0] vrd_addr;
  logic [7:0] vrd_data;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_sof, pix_eol, pix_eof;
  logic       busy;
  logic [7:0] frame_cnt;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       sof, eol, eof;
  } xfer_t;

  xfer_t      q[$];
  logic [7:0] ram[256];
  int         busy_cnt = 0;

  video_scanout dut (
    .clock(clock), .reset(reset), .cpu_we(cpu_we), .cpu_mar(cpu_mar),
    .vrd_addr(vrd_addr), .vrd_data(vrd_data), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  // synchronous read port: data valid the cycle after the address
  always @(posedge clock) vrd_data <= ram[vrd_addr];

  // transfer monitor
  always @(posedge clock)
    if (reset && pix_valid && pix_ready)
      q.push_back({pix_data, pix_sof, pix_eol, pix_eof});

  always @(negedge clock) if (busy) busy_cnt <= busy_cnt + 1;

  // mismatches of q[base +: n] against consecutive frames starting at index 0
  function automatic int seq_errs(int base, int n);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      int k = i % 80;
      xfer_t x = q[base + i];
      if (x.d !== 8'(k) || x.sof !== (k == 0) || x.eol !== (k % 10 == 9) ||
          x.eof !== (k == 79)) e++;
    end
    return e;
  endfunction

  task automatic wait_done(input logic [7:0] target, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (frame_cnt == target && !busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 0; cpu_we = 0; cpu_mar = 0; pix_ready = 1;
    repeat (3) @(negedge clock);
    checks++;
    if ({pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, frame_cnt} !== 21'd0)
      $display("FAIL reset_outputs: got valid=%b data=%0d flags=%b%b%b busy=%b fc=%0d want all 0",
               pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, frame_cnt);
    else passed++;
    checks++;
    if (vrd_addr !== 8'd128) $display("FAIL reset_addr: got %0d want 128", vrd_addr);
    else passed++;
  endtask

  task automatic test_first_frame;
    int b0 = q.size();
    int c0 = busy_cnt;
    bit ok;
    reset = 1;
    wait_done(8'd1, ok);
    checks++;
    if (!ok) $display("FAIL frame1_timeout: fc=%0d busy=%b want fc=1 idle", frame_cnt, busy);
    else passed++;
    checks++;
    if (q.size() - b0 !== 80) $display("FAIL frame1_count: got %0d want 80", q.size() - b0);
    else passed++;
    checks++;
    if (q.size() - b0 == 80 && seq_errs(b0, 80) == 0) passed++;
    else $display("FAIL frame1_seq: bad entries, size %0d want 80 in order", q.size() - b0);
    checks++;
    if (busy_cnt - c0 !== 240) $display("FAIL frame1_cycles: got %0d want 240", busy_cnt - c0);
    else passed++;
  endtask

  task automatic test_idle_hold;
    int b0 = q.size();
    repeat (30) @(negedge clock);
    checks++;
    if (busy !== 0 || frame_cnt !== 8'd1 || q.size() != b0)
      $display("FAIL idle_hold: busy=%b fc=%0d new=%0d want 0/1/0", busy, frame_cnt, q.size() - b0);
    else passed++;
    checks++;
    if (vrd_addr !== 8'd207) $display("FAIL idle_addr: got %0d want 207", vrd_addr);
    else passed++;
  endtask

  task automatic test_window_edges;
    int b0 = q.size();
    bit ok;
    cpu_we = 1; cpu_mar = 8'd127; @(negedge clock);
    cpu_mar = 8'd208; @(negedge clock);
    cpu_we = 0;
    repeat (20) @(negedge clock);
    checks++;
    if (busy !== 0 || frame_cnt !== 8'd1)
      $display("FAIL outside_window: busy=%b fc=%0d want 0/1", busy, frame_cnt);
    else passed++;
    cpu_we = 1; cpu_mar = 8'd207; @(negedge clock);
    cpu_we = 0;
    wait_done(8'd2, ok);
    checks++;
    if (!ok) $display("FAIL top_edge_frame: fc=%0d want 2", frame_cnt);
    else passed++;
    checks++;
    if (q.size() - b0 == 80 && seq_errs(b0, 80) == 0) passed++;
    else $display("FAIL top_edge_seq: got %0d entries want 80 in order", q.size() - b0);
  endtask

  task automatic test_backpressure;
    int b0 = q.size();
    int bad = 0;
    bit ok, seen = 0;
    cpu_we = 1; cpu_mar = 8'd128; @(negedge clock);
    cpu_we = 0;
    for (int i = 0; i < 200; i++) begin
      if (pix_valid && pix_data == 8'd5) begin seen = 1; break; end
      @(negedge clock);
    end
    checks++;
    if (!seen) $display("FAIL bp_reach_byte5: got data=%0d want 5 within bound", pix_data);
    else passed++;
    pix_ready = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if (pix_valid !== 1 || pix_data !== 8'd5 || {pix_sof, pix_eol, pix_eof} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL bp_stable: %0d unstable cycles want 0", bad);
    else passed++;
    pix_ready = 1;
    wait_done(8'd3, ok);
    checks++;
    if (!ok) $display("FAIL bp_timeout: fc=%0d want 3", frame_cnt);
    else passed++;
    checks++;
    if (q.size() - b0 == 80 && seq_errs(b0, 80) == 0) passed++;
    else $display("FAIL bp_seq: got %0d entries want 80 in order", q.size() - b0);
  endtask

  task automatic test_back_to_back;
    int b0 = q.size();
    bit ok;
    // first edge marks dirty, second edge coincides with IDLE->ADDR
    cpu_we = 1; cpu_mar = 8'd130; @(negedge clock);
    checks++;
    if (busy !== 0) $display("FAIL b2b_pre: busy=%b want 0", busy);
    else passed++;
    @(negedge clock);
    cpu_we = 0;
    wait_done(8'd5, ok);
    checks++;
    if (!ok) $display("FAIL b2b_frames: fc=%0d want 5", frame_cnt);
    else passed++;
    repeat (20) @(negedge clock);
    checks++;
    if (busy !== 0 || frame_cnt !== 8'd5 || q.size() - b0 != 160)
      $display("FAIL b2b_count: busy=%b fc=%0d n=%0d want 0/5/160", busy, frame_cnt, q.size() - b0);
    else passed++;
    checks++;
    if (q.size() - b0 == 160 && seq_errs(b0, 160) == 0) passed++;
    else $display("FAIL b2b_seq: entries out of order");
  endtask

  task automatic test_reset_midframe;
    int b0;
    bit ok, seen = 0;
    cpu_we = 1; cpu_mar = 8'd150; @(negedge clock);
    cpu_we = 0;
    for (int i = 0; i < 400; i++) begin
      if (pix_valid && pix_data == 8'd40) begin seen = 1; break; end
      @(negedge clock);
    end
    checks++;
    if (!seen) $display("FAIL rst_reach_byte40: got data=%0d want 40", pix_data);
    else passed++;
    #1 reset = 0;
    #1;
    checks++;
    if ({pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, frame_cnt} !== 21'd0)
      $display("FAIL rst_async: valid=%b data=%0d busy=%b fc=%0d want all 0",
               pix_valid, pix_data, busy, frame_cnt);
    else passed++;
    @(negedge clock);
    b0 = q.size();
    reset = 1;
    wait_done(8'd1, ok);
    checks++;
    if (!ok) $display("FAIL rst_refresh: fc=%0d want 1", frame_cnt);
    else passed++;
    checks++;
    if (q.size() - b0 == 80 && seq_errs(b0, 80) == 0) passed++;
    else $display("FAIL rst_seq: got %0d entries want 80 from index 0", q.size() - b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i - 128);
    vrd_data = 0;
    test_reset;
    test_first_frame;
    test_idle_hold;
    test_window_edges;
    test_backpressure;
    test_back_to_back;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
